otter_data_mem_ctrl: RTL and testbench

Responder for the data-memory request lines driven by the OTTER control decoder (MEM_READ2 / MEM_WRITE) in the MEM stage. It checks alignment, converts byte/half/word accesses into a word-aligned bus transaction with byte enables and waits for a variable-latency acknowledge. It returns sign- or zero-extended load data and stalls the core until the access completes, errors, or times out.

---
 rtl/otter_data_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_otter_data_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_data_mem_ctrl.sv
// Data-memory responder for the OTTER MEM stage: alignment checks, byte-lane
// encoding, a variable-latency bus handshake with timeout, and load-data extension.
module otter_data_mem_ctrl #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MEM_READ2,
  input  logic                  MEM_WRITE,
  input  logic [1:0]            MEM_SIZE,
  input  logic                  MEM_SIGN,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR2,
  input  logic [31:0]           MEM_DIN2,
  output logic [31:0]           MEM_DOUT2,
  output logic                  MEM_VALID,
  output logic                  MEM_STALL,
  output logic                  MEM_ERR,
  output logic                  BUS_REQ,
  output logic                  BUS_WE,
  output logic [ADDR_WIDTH-1:0] BUS_ADDR,
  output logic [3:0]            BUS_BE,
  output logic [31:0]           BUS_WDATA,
  input  logic [31:0]           BUS_RDATA,
  input  logic                  BUS_ACK
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           dout_q, dout_d;
  logic                  terr_q, terr_d;

  logic        req, illegal, start, timeout_hit;
  logic [3:0]  be_enc;
  logic [31:0] wdata_enc, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req     = MEM_READ2 | MEM_WRITE;
  assign illegal = (MEM_READ2 & MEM_WRITE) | (MEM_SIZE == 2'b11) |
                   ((MEM_SIZE == 2'b01) & MEM_ADDR2[0]) |
                   ((MEM_SIZE == 2'b10) & (|MEM_ADDR2[1:0]));
  assign start       = (state_q == IDLE) & req & ~illegal;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    be_enc    = 4'b1111;
    wdata_enc = MEM_DIN2;
    case (MEM_SIZE)
      2'b00: begin
        be_enc    = 4'b0001 << MEM_ADDR2[1:0];
        wdata_enc = {4{MEM_DIN2[7:0]}};
      end
      2'b01: begin
        be_enc    = 4'b0011 << MEM_ADDR2[1:0];
        wdata_enc = {2{MEM_DIN2[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the latched offset; the bus word itself is only valid with ACK.
  always_comb begin
    lane_b   = BUS_RDATA[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    load_ext = BUS_RDATA;
    case (size_q)
      2'b00:   load_ext = sign_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = sign_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          we_d    = MEM_WRITE;
          size_d  = MEM_SIZE;
          sign_d  = MEM_SIGN;
          off_d   = MEM_ADDR2[1:0];
          addr_d  = {MEM_ADDR2[ADDR_WIDTH-1:2], 2'b00};
          be_d    = be_enc;
          wdata_d = wdata_enc;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (BUS_ACK) begin
          dout_d  = we_q ? '0 : load_ext;
          state_d = DONE;
        end else if (timeout_hit) begin
          dout_d  = '0;
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      terr_q  <= terr_d;
    end
  end

  assign BUS_REQ   = (state_q == BUSY);
  assign BUS_WE    = we_q;
  assign BUS_ADDR  = addr_q;
  assign BUS_BE    = be_q;
  assign BUS_WDATA = wdata_q;
  assign MEM_DOUT2 = dout_q;
  assign MEM_VALID = (state_q == DONE);
  assign MEM_STALL = start | (state_q == BUSY);
  assign MEM_ERR   = ((state_q == IDLE) & req & illegal) | terr_q;

endmodule

// File: tb/tb_otter_data_mem_ctrl.sv
// Scoreboard bench for otter_data_mem_ctrl: expected {err,dout} pushed at request,
// popped when MEM_VALID is seen; bus-side fields checked cycle by cycle.
module tb_otter_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MEM_READ2 = 1'b0, MEM_WRITE = 1'b0, MEM_SIGN = 1'b0;
  logic [1:0]  MEM_SIZE = 2'b00;
  logic [31:0] MEM_ADDR2 = '0, MEM_DIN2 = '0;
  logic [31:0] MEM_DOUT2;
  logic        MEM_VALID, MEM_STALL, MEM_ERR;
  logic        BUS_REQ, BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_BE;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA = '0;
  logic        BUS_ACK = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] sb_q[$];
  logic [31:0] last_dout = '0;

  always #5 CLK = ~CLK;

  otter_data_mem_ctrl #(.TIMEOUT(4), .ADDR_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .MEM_READ2(MEM_READ2), .MEM_WRITE(MEM_WRITE), .MEM_SIZE(MEM_SIZE),
    .MEM_SIGN(MEM_SIGN), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_DOUT2(MEM_DOUT2), .MEM_VALID(MEM_VALID), .MEM_STALL(MEM_STALL),
    .MEM_ERR(MEM_ERR), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_BE(BUS_BE), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK)
  );

  task automatic clear_req();
    MEM_READ2 = 1'b0; MEM_WRITE = 1'b0; MEM_SIZE = 2'b00; MEM_SIGN = 1'b0;
    MEM_ADDR2 = '0;   MEM_DIN2 = '0;
  endtask

  task automatic pop_check(input string name);
    logic [32:0] exp;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s result: scoreboard empty at MEM_VALID", name);
    end else begin
      exp = sb_q.pop_front();
      if ({MEM_ERR, MEM_DOUT2} !== exp) begin
        miscompares++;
        $display("FAIL %s result: err/dout=%b/%h required %b/%h", name, MEM_ERR, MEM_DOUT2,
                 exp[32], exp[31:0]);
      end
      last_dout = exp[31:0];
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] addr, input logic [31:0] din,
                           input int waits, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_dout,
                           input string name);
    @(negedge CLK);
    MEM_READ2 = rd; MEM_WRITE = wr; MEM_SIZE = sz; MEM_SIGN = sg;
    MEM_ADDR2 = addr; MEM_DIN2 = din;
    sb_q.push_back({1'b0, exp_dout});
    #1;
    vectors++;
    if (MEM_STALL !== 1'b1 || MEM_ERR !== 1'b0 || BUS_REQ !== 1'b0 || MEM_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start: stall=%b err=%b req=%b valid=%b required 1 0 0 0", name,
               MEM_STALL, MEM_ERR, BUS_REQ, MEM_VALID);
    end
    for (int i = 0; i <= waits; i++) begin
      @(negedge CLK);
      vectors++;
      if (BUS_REQ !== 1'b1 || MEM_STALL !== 1'b1 || MEM_VALID !== 1'b0 || MEM_ERR !== 1'b0 ||
          BUS_WE !== wr || BUS_ADDR !== exp_addr || BUS_BE !== exp_be ||
          (wr === 1'b1 && BUS_WDATA !== exp_wdata)) begin
        miscompares++;
        $display("FAIL %s busy%0d: req=%b stall=%b valid=%b we=%b addr=%h be=%b wdata=%h required 1 1 0 %b %h %b %h",
                 name, i, BUS_REQ, MEM_STALL, MEM_VALID, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA,
                 wr, exp_addr, exp_be, exp_wdata);
      end
      if (i == waits) begin
        BUS_ACK = 1'b1; BUS_RDATA = rdata;
      end
    end
    @(negedge CLK);
    BUS_ACK = 1'b0; BUS_RDATA = 32'h5A5A_5A5A;
    vectors++;
    if (MEM_VALID !== 1'b1 || MEM_STALL !== 1'b0 || BUS_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done: valid=%b stall=%b req=%b required 1 0 0", name, MEM_VALID,
               MEM_STALL, BUS_REQ);
    end
    pop_check(name);
    clear_req();
  endtask

  task automatic test_illegal(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic [31:0] addr, input string name);
    @(negedge CLK);
    MEM_READ2 = rd; MEM_WRITE = wr; MEM_SIZE = sz; MEM_ADDR2 = addr; MEM_DIN2 = 32'h1111_2222;
    #1;
    vectors++;
    if (MEM_ERR !== 1'b1 || MEM_STALL !== 1'b0 || BUS_REQ !== 1'b0 || MEM_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: err=%b stall=%b req=%b valid=%b required 1 0 0 0", name, MEM_ERR,
               MEM_STALL, BUS_REQ, MEM_VALID);
    end
    @(negedge CLK);
    clear_req();
    #1;
    vectors++;
    if (BUS_REQ !== 1'b0 || MEM_VALID !== 1'b0 || MEM_STALL !== 1'b0 || MEM_ERR !== 1'b0 ||
        MEM_DOUT2 !== last_dout) begin
      miscompares++;
      $display("FAIL %s after: req=%b valid=%b stall=%b err=%b dout=%h required 0 0 0 0 %h",
               name, BUS_REQ, MEM_VALID, MEM_STALL, MEM_ERR, MEM_DOUT2, last_dout);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    vectors++;
    if (BUS_REQ !== 1'b0 || BUS_WE !== 1'b0 || BUS_ADDR !== '0 || BUS_BE !== '0 ||
        BUS_WDATA !== '0 || MEM_DOUT2 !== '0 || MEM_VALID !== 1'b0 || MEM_STALL !== 1'b0 ||
        MEM_ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: req=%b we=%b addr=%h be=%b wdata=%h dout=%h valid=%b stall=%b err=%b required all 0",
               BUS_REQ, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA, MEM_DOUT2, MEM_VALID, MEM_STALL, MEM_ERR);
    end
    RST = 1'b0;
  endtask

  task automatic test_timeout();
    @(negedge CLK);
    MEM_READ2 = 1'b1; MEM_SIZE = 2'b10; MEM_ADDR2 = 32'h0000_4000;
    sb_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      vectors++;
      if (BUS_REQ !== 1'b1 || MEM_STALL !== 1'b1 || MEM_ERR !== 1'b0 || MEM_VALID !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout busy%0d: req=%b stall=%b err=%b valid=%b required 1 1 0 0", i,
                 BUS_REQ, MEM_STALL, MEM_ERR, MEM_VALID);
      end
    end
    @(negedge CLK);
    vectors++;
    if (MEM_VALID !== 1'b1 || BUS_REQ !== 1'b0 || MEM_STALL !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout done: valid=%b req=%b stall=%b required 1 0 0", MEM_VALID,
               BUS_REQ, MEM_STALL);
    end
    pop_check("timeout");
    clear_req();
    @(negedge CLK);
    vectors++;
    if (MEM_VALID !== 1'b0 || MEM_ERR !== 1'b0 || BUS_REQ !== 1'b0 || MEM_STALL !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout idle: valid=%b err=%b req=%b stall=%b required 0 0 0 0",
               MEM_VALID, MEM_ERR, BUS_REQ, MEM_STALL);
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge CLK);
    MEM_READ2 = 1'b1; MEM_SIZE = 2'b10; MEM_ADDR2 = 32'h0000_5000;
    repeat (2) @(negedge CLK);
    vectors++;
    if (BUS_REQ !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_busy pre: req=%b required 1", BUS_REQ);
    end
    RST = 1'b1;
    clear_req();
    @(negedge CLK);
    vectors++;
    if (BUS_REQ !== 1'b0 || MEM_STALL !== 1'b0 || MEM_VALID !== 1'b0 || MEM_ERR !== 1'b0 ||
        MEM_DOUT2 !== '0 || BUS_ADDR !== '0 || BUS_BE !== '0 || BUS_WE !== 1'b0 ||
        BUS_WDATA !== '0) begin
      miscompares++;
      $display("FAIL rst_busy: req=%b stall=%b valid=%b err=%b dout=%h addr=%h be=%b required all 0",
               BUS_REQ, MEM_STALL, MEM_VALID, MEM_ERR, MEM_DOUT2, BUS_ADDR, BUS_BE);
    end
    RST = 1'b0;
    last_dout = '0;
    BUS_ACK = 1'b1; BUS_RDATA = 32'hFFFF_FFFF;
    @(negedge CLK);
    BUS_ACK = 1'b0;
    vectors++;
    if (MEM_VALID !== 1'b0 || BUS_REQ !== 1'b0 || MEM_DOUT2 !== '0) begin
      miscompares++;
      $display("FAIL stray_ack: valid=%b req=%b dout=%h required 0 0 00000000", MEM_VALID,
               BUS_REQ, MEM_DOUT2);
    end
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5004, '0, 1, 32'hCAFE_BABE,
              32'h0000_5004, 4'b1111, '0, 32'hCAFE_BABE, "fresh_load");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    // word load, single-cycle ACK
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, '0, 0, 32'h8765_4321,
              32'h0000_1000, 4'b1111, '0, 32'h8765_4321, "word_load");
    // byte loads: sign/zero extension and lane selection
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, '0, 0, 32'h80FF_FFFF,
              32'h0000_1000, 4'b1000, '0, 32'hFFFF_FF80, "byte_load_s");
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, '0, 0, 32'h80FF_FFFF,
              32'h0000_1000, 4'b1000, '0, 32'h0000_0080, "byte_load_u");
    do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1001, '0, 1, 32'h0000_7F00,
              32'h0000_1000, 4'b0010, '0, 32'h0000_007F, "byte_load_pos");
    // half store with ACK in the last counting cycle
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF,
              32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0, "half_store");
    do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, '0, 2, 32'h8001_1234,
              32'h0000_2000, 4'b1100, '0, 32'hFFFF_8001, "half_load_s");
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2000, '0, 0, 32'h8001_F234,
              32'h0000_2000, 4'b0011, '0, 32'h0000_F234, "half_load_u");
    test_illegal(1'b1, 1'b0, 2'b10, 32'h0000_2001, "misaligned_word");
    test_illegal(1'b1, 1'b1, 2'b10, 32'h0000_2000, "read_and_write");
    test_illegal(1'b1, 1'b0, 2'b11, 32'h0000_2000, "illegal_size");
    test_illegal(1'b0, 1'b1, 2'b01, 32'h0000_2003, "misaligned_half");
    test_timeout();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4004, '0, 3, 32'h1357_9BDF,
              32'h0000_4004, 4'b1111, '0, 32'h1357_9BDF, "ack_at_limit");
    // back-to-back: each request follows the previous DONE with no idle gap
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56A5, 0, '0,
              32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 32'h0, "b2b_byte_store");
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_3008, 32'h0F1E_2D3C, 1, '0,
              32'h0000_3008, 4'b1111, 32'h0F1E_2D3C, 32'h0, "b2b_word_store");
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_3002, '0, 0, 32'h00C3_0000,
              32'h0000_3000, 4'b0100, '0, 32'h0000_00C3, "b2b_byte_load");
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
